// File: rtl/ram_burst_writer.sv
// Burst write controller for a single-port synchronous RAM: streams valid/ready words to consecutive addresses.
// Define RAM_WRITER_VERIFY_EN to read back and compare each word after writing it (sticky err/err_addr).
module ram_burst_writer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr
);

`ifdef RAM_WRITER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VRD, S_VCMP, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  in_ready_q, busy_q, done_q;
    logic                  handshake;

`ifdef RAM_WRITER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
`endif

    assign handshake = in_ready_q & in_valid;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        words_d     = words_q;
`ifdef RAM_WRITER_VERIFY_EN
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    remaining_d = count;
                    words_d     = '0;
                    state_d     = (count == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (handshake) begin
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    words_d     = words_q + (ADDR_WIDTH+1)'(1);
`ifdef RAM_WRITER_VERIFY_EN
                    hold_addr_d = cur_addr_q;
                    hold_data_d = in_data;
                    state_d     = S_VRD;
`else
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) state_d = S_DONE;
`endif
                end
            end
`ifdef RAM_WRITER_VERIFY_EN
            S_VRD:  state_d = S_VCMP;
            S_VCMP: begin
                // Only the first mismatch is recorded; err stays set until reset.
                if ((ram_q != hold_data_q) && !err_q) begin
                    err_d      = 1'b1;
                    err_addr_d = hold_addr_q;
                end
                state_d = (remaining_q != '0) ? S_WRITE : S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RAM_WRITER_VERIFY_EN
            hold_addr_q <= '0;
            hold_data_q <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            in_ready_q  <= (state_d == S_WRITE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
`ifdef RAM_WRITER_VERIFY_EN
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign ram_wren      = handshake;
    assign ram_data      = in_data;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_q;

`ifdef RAM_WRITER_VERIFY_EN
    assign ram_address = ((state_q == S_VRD) || (state_q == S_VCMP)) ? hold_addr_q : cur_addr_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;
`else
    logic unused_ram_q_parity;
    assign unused_ram_q_parity = ^ram_q;
    assign ram_address = cur_addr_q;
    assign err         = 1'b0;
    assign err_addr    = '0;
`endif

endmodule

// File: tb/tb_ram_burst_writer.sv
// Self-checking bench for ram_burst_writer: bursts against a behavioural RAM and expected-write model.
// Honours RAM_WRITER_VERIFY_EN the same way as the design (readback cycles and corruption test).
module tb_ram_burst_writer;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef RAM_WRITER_VERIFY_EN
    localparam int VGAP = 2;
`else
    localparam int VGAP = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy, done;
    logic [AW:0]   words_written;
    logic          err;
    logic [AW-1:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] burst_data [0:DEPTH-1];
    int            corrupt_addr = -1;

    ram_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy), .done(done), .words_written(words_written), .err(err), .err_addr(err_addr)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM with registered read; optionally corrupts one address.
    always @(posedge clock) begin
        if (ram_wren)
            mem[ram_address] <= (int'(ram_address) == corrupt_addr) ? ~ram_data : ram_data;
        ram_q <= mem[ram_address];
    end

    // mode 0: valid always high, 1: random valid, 2: pattern 1,0,0,1,1 with a stray start
    task automatic run_burst(input int base, input int cnt, input int mode);
        int idx = 0;
        int gap = 0;
        int cyc = 0;
        logic v;
        @(negedge clock);
        start = 1'b1; base_addr = AW'(base); count = (AW+1)'(cnt);
        if (cnt > 0) begin
            while (idx < cnt && cyc < 1000) begin
                @(negedge clock);
                start = 1'b0;
                if (mode == 2 && cyc == 1) begin
                    start = 1'b1; base_addr = AW'(base + 20); count = (AW+1)'(7);
                end
                case (mode)
                    0: v = 1'b1;
                    1: v = ($urandom_range(0, 2) != 0);
                    default: v = (cyc % 5 == 0) || (cyc % 5 >= 3);
                endcase
                in_valid = v;
                in_data  = burst_data[idx];
                #1;
                n_checks++;
                if (in_ready !== (gap == 0)) begin
                    n_fail++; $display("FAIL in_ready idx=%0d cyc=%0d got=%b exp=%b", idx, cyc, in_ready, gap == 0);
                end
                n_checks++;
                if (ram_wren !== (v && gap == 0)) begin
                    n_fail++; $display("FAIL ram_wren idx=%0d cyc=%0d got=%b exp=%b", idx, cyc, ram_wren, v && gap == 0);
                end
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++; $display("FAIL busy_mid cyc=%0d got busy=%b done=%b exp busy=1 done=0", cyc, busy, done);
                end
                n_checks++;
                if (words_written !== (AW+1)'(idx)) begin
                    n_fail++; $display("FAIL words_mid got=%0d exp=%0d", words_written, idx);
                end
`ifdef RAM_WRITER_VERIFY_EN
                if (gap == VGAP && idx > 0) begin
                    n_checks++;
                    if (ram_address !== AW'((base + idx - 1) % DEPTH)) begin
                        n_fail++; $display("FAIL vrd_addr got=%h exp=%h", ram_address, AW'((base + idx - 1) % DEPTH));
                    end
                end
`endif
                if (gap == 0 && v) begin
                    n_checks++;
                    if (ram_address !== AW'((base + idx) % DEPTH) || ram_data !== burst_data[idx]) begin
                        n_fail++; $display("FAIL write idx=%0d got addr=%h data=%h exp addr=%h data=%h",
                                           idx, ram_address, ram_data, AW'((base + idx) % DEPTH), burst_data[idx]);
                    end
                    idx++;
                    gap = VGAP;
                end else if (gap > 0) begin
                    gap--;
                end
                cyc++;
            end
            n_checks++;
            if (idx != cnt) begin
                n_fail++; $display("FAIL burst_timeout got=%0d exp=%0d words", idx, cnt);
            end
            for (int g = 0; g < VGAP; g++) begin
                @(negedge clock);
                #1;
                n_checks++;
                if (in_ready !== 1'b0 || ram_wren !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL verify_gap got ready=%b wren=%b done=%b exp 0 0 0", in_ready, ram_wren, done);
                end
            end
        end
        @(negedge clock);
        start = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || ram_wren !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse got done=%b busy=%b wren=%b ready=%b exp 1 1 0 0", done, busy, ram_wren, in_ready);
        end
        n_checks++;
        if (words_written !== (AW+1)'(cnt)) begin
            n_fail++; $display("FAIL words_final got=%0d exp=%0d", words_written, cnt);
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after got done=%b busy=%b exp 0 0", done, busy);
        end
        n_checks++;
        if (ram_address !== AW'((base + cnt) % DEPTH)) begin
            n_fail++; $display("FAIL idle_addr got=%h exp=%h", ram_address, AW'((base + cnt) % DEPTH));
        end
        for (int i = 0; i < cnt; i++) begin
            if ((base + i) % DEPTH != corrupt_addr) begin
                n_checks++;
                if (mem[(base + i) % DEPTH] !== burst_data[i]) begin
                    n_fail++; $display("FAIL ram_content addr=%h got=%h exp=%h", (base + i) % DEPTH, mem[(base + i) % DEPTH], burst_data[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || ram_wren !== 1'b0 ||
            words_written !== '0 || err !== 1'b0 || err_addr !== '0 || ram_address !== '0) begin
            n_fail++; $display("FAIL reset_state got busy=%b done=%b ready=%b wren=%b ww=%0d err=%b ea=%h addr=%h exp all 0",
                               busy, done, in_ready, ram_wren, words_written, err, err_addr, ram_address);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_burst();
        for (int i = 0; i < 8; i++) burst_data[i] = DW'(8'hA0 + i);
        run_burst(0, 8, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) burst_data[i] = DW'(8'h11 + i);
        run_burst(8'h3E, 4, 0);
    endtask

    task automatic test_zero_count();
        run_burst(int'($urandom_range(0, DEPTH - 1)), 0, 0);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) burst_data[i] = DW'($urandom);
        run_burst(int'($urandom_range(0, DEPTH - 1)), 3, 2);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clock);
        start = 1'b1; base_addr = AW'(10); count = (AW+1)'(5);
        @(negedge clock);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        repeat (VGAP + 1) @(negedge clock);
        in_data = 8'h66;
        repeat (VGAP + 1) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || ram_wren !== 1'b0 ||
            words_written !== '0 || ram_address !== '0) begin
            n_fail++; $display("FAIL reset_mid got busy=%b done=%b ready=%b wren=%b ww=%0d addr=%h exp 0",
                               busy, done, in_ready, ram_wren, words_written, ram_address);
        end
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(negedge clock);
            #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL no_done_after_reset got done=%b busy=%b exp 0 0", done, busy);
            end
        end
        for (int i = 0; i < 5; i++) burst_data[i] = DW'($urandom);
        run_burst(20, 5, 0);
    endtask

    task automatic test_random_bursts();
        for (int b = 0; b < 6; b++) begin
            int cnt = (b == 5) ? DEPTH : int'($urandom_range(1, 24));
            for (int i = 0; i < cnt; i++) burst_data[i] = DW'($urandom);
            run_burst(int'($urandom_range(0, DEPTH - 1)), cnt, int'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_err_flag();
`ifdef RAM_WRITER_VERIFY_EN
        corrupt_addr = 5;
        for (int i = 0; i < 3; i++) burst_data[i] = DW'($urandom);
        run_burst(4, 3, 0);
        n_checks++;
        if (err !== 1'b1 || err_addr !== AW'(5)) begin
            n_fail++; $display("FAIL verify_err got err=%b addr=%h exp err=1 addr=05", err, err_addr);
        end
        corrupt_addr = -1;
`else
        n_checks++;
        if (err !== 1'b0 || err_addr !== '0) begin
            n_fail++; $display("FAIL err_tied got err=%b addr=%h exp 0 0", err, err_addr);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_basic_burst();
        test_wrap();
        test_zero_count();
        test_gaps();
        test_reset_mid_burst();
        test_random_bursts();
        test_err_flag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
